shifter_pipe: RTL and testbench
===============================

# shifter_pipe

Parametrised, two-stage pipelined barrel shifter that succeeds the single-cycle 16-bit shift unit. It supports five shift/rotate modes on a WIDTH-bit operand, uses a valid/ready handshake with full backpressure, and carries an opaque tag through with each operation. Optional carry and zero flags are produced for the flag register. It sits between the decode/issue stage and writeback as the execute unit for shift-class instructions.

## Interface
Parameters:
- WIDTH, 16, operand width; must be a power of two, ≥ 4.
- TAG_W, 4, width of the pass-through tag (e.g. destination register index).
- SHAMT_W, $clog2(WIDTH), derived; not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_mode  in  3  operation code.
- in_tag  in  TAG_W  carried unchanged to out_tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_carry  out  1  last bit shifted or rotated out.
- out_zero  out  1  out_data == 0.

## Operation
- Modes:
  - 000 SLL: zero fill.
  - 001 SRA: sign fill.
  - 010 ROR.
  - 011 pass-through.
  - 100 SRL: zero fill.
  - 101 ROL.
  - 110/111 pass-through.
- Codes 000–010 match the legacy 2-bit encoding.
- Shift is log-structured, one level per shamt bit.
- Stage A applies levels for shamt[L-1:0], where L = ceil(SHAMT_W/2). Stage B applies the remaining levels.
- Carry (computed in stage A from the original operand, then registered):
  - shamt 0 or pass-through: 0.
  - SLL/ROL: in_data[WIDTH-shamt].
  - SRL/SRA/ROR: in_data[shamt-1].
- Zero is computed combinationally in stage B from the final result.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - Stage B register advances when empty or out_ready=1.
  - Stage A register advances when empty or stage B advances.
  - in_ready = !A_valid || B_advances.
- out_data/out_tag/out_carry/out_zero hold stable while out_valid && !out_ready.
- Order is preserved; there is no drop or duplication.

## Timing
- Latency: an operation accepted at edge N is presented with out_valid=1 after edge N+1. That is 2 cycles.
- Throughput: 1 operation per cycle with out_ready held high.
- Reset (rst_n=0 at an edge): both valid bits are cleared, and the data registers are cleared to 0.
  - Resulting outputs: out_valid=0, out_data=0, out_tag=0, out_carry=0, out_zero=0, in_ready=1 in the following cycle.
  - Reset mid-operation discards all in-flight operations.
- Full pipeline with out_ready=0: in_ready=0. No new acceptance occurs until out_ready rises.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: both transfers occur in the same cycle, with no bubble.
- in_* are ignored when in_valid=0 or in_ready=0.

## Configuration
- SHIFTER_FLAGS_EN defined: out_carry and out_zero are computed as specified, and the carry bit is pipelined alongside the data.
- Undefined: out_carry and out_zero are tied to 0, and no flag logic or flag registers are built. All ports remain present.

## Structure
- Package shifter_pkg holds:
  - mode localparams: MODE_SLL, MODE_SRA, MODE_ROR, MODE_PASS, MODE_SRL, MODE_ROL;
  - a 3-bit shift_mode_t typedef.
- Sub-module shifter_level (combinational): one log level. Parameters are WIDTH and DIST. Inputs are data, enable, and mode. Output is the shifted data.
  - It is instantiated SHAMT_W times across the two stages.

## Test plan
- WIDTH=16, SLL 0x0001 shamt 15 → 0x8000, carry 0, zero 0; SLL 0x8000 shamt 1 → 0x0000, carry 1, zero 1.
- SRA 0x8000 shamt 4 → 0xF800, carry 0; SRL 0x0003 shamt 1 → 0x0001, carry 1.
- ROR 0x0001 shamt 1 → 0x8000, carry 1; ROL 0x8001 shamt 4 → 0x0018, carry 0; mode 110 on 0x1234 shamt 5 → 0x1234, carry 0.
- 8 back-to-back ops (tags 0–7) with out_ready=1: outputs appear every cycle, starting 2 cycles after the first accept, with tags in order.
- 3 ops offered while out_ready=0: 2 accepted, then in_ready=0. out_data is held stable. After out_ready=1, all 3 emerge in order with no loss.
- rst_n=0 for one edge with both stages full: out_valid=0 and in_ready=1 next cycle, and no stale result emerges afterwards.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared mode encodings for the pipelined barrel shifter.
// Codes 000-010 keep the legacy 2-bit shift encoding.
package shifter_pkg;

   typedef logic [2:0] shift_mode_t;

   localparam shift_mode_t MODE_SLL  = 3'b000;
   localparam shift_mode_t MODE_SRA  = 3'b001;
   localparam shift_mode_t MODE_ROR  = 3'b010;
   localparam shift_mode_t MODE_PASS = 3'b011;
   localparam shift_mode_t MODE_SRL  = 3'b100;
   localparam shift_mode_t MODE_ROL  = 3'b101;

endpackage

// File: rtl/shifter_level.sv
// One log level of the barrel shifter: shifts or rotates by DIST
// when enabled, otherwise passes the operand through.
module shifter_level
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             enable,
   input  shift_mode_t      mode,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] moved;

   always_comb begin
      moved = data;
      case (mode)
         MODE_SLL: moved = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
         MODE_SRL: moved = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
         MODE_SRA: moved = {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]};
         MODE_ROR: moved = {data[DIST-1:0], data[WIDTH-1:DIST]};
         MODE_ROL: moved = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
         default:  moved = data;
      endcase
   end

   assign result = enable ? moved : data;

endmodule

// File: rtl/shifter_pipe.sv
// Two-stage pipelined barrel shifter with valid/ready handshake.
// Define SHIFTER_FLAGS_EN to build the carry and zero flag logic.
module shifter_pipe
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TAG_W   = 4,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [2:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_carry,
   output logic               out_zero
);

   localparam int L = (SHAMT_W + 1) / 2;
   localparam int H = SHAMT_W - L;

   logic               a_valid;
   logic               b_valid;
   logic               a_adv;
   logic               b_adv;
   logic               in_fire;
   logic               b_load;
   logic [WIDTH-1:0]   a_data;
   logic [WIDTH-1:0]   b_data;
   logic [H-1:0]       a_shamt;
   shift_mode_t        a_mode;
   logic [TAG_W-1:0]   a_tag;
   logic [TAG_W-1:0]   b_tag;
   logic [L:0][WIDTH-1:0] a_chain;
   logic [H:0][WIDTH-1:0] b_chain;

   assign b_adv    = !b_valid || out_ready;
   assign a_adv    = !a_valid || b_adv;
   assign in_ready = a_adv;
   assign in_fire  = in_valid && a_adv;
   assign b_load   = b_adv && a_valid;

   assign a_chain[0] = in_data;
   assign b_chain[0] = a_data;

   for (genvar i = 0; i < L; i++) begin : g_lvl_a
      shifter_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << i)
      ) u_lvl (
         .data   (a_chain[i]),
         .enable (in_shamt[i]),
         .mode   (in_mode),
         .result (a_chain[i+1])
      );
   end

   for (genvar j = 0; j < H; j++) begin : g_lvl_b
      shifter_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << (j + L))
      ) u_lvl (
         .data   (b_chain[j]),
         .enable (a_shamt[j]),
         .mode   (a_mode),
         .result (b_chain[j+1])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         b_valid <= 1'b0;
         a_data  <= '0;
         a_shamt <= '0;
         a_mode  <= MODE_SLL;
         a_tag   <= '0;
         b_data  <= '0;
         b_tag   <= '0;
      end else begin
         if (a_adv) a_valid <= in_valid;
         if (in_fire) begin
            a_data  <= a_chain[L];
            a_shamt <= in_shamt[SHAMT_W-1:L];
            a_mode  <= in_mode;
            a_tag   <= in_tag;
         end
         if (b_adv) b_valid <= a_valid;
         if (b_load) begin
            b_data <= b_chain[H];
            b_tag  <= a_tag;
         end
      end
   end

   assign out_valid = b_valid;
   assign out_data  = b_data;
   assign out_tag   = b_tag;

`ifdef SHIFTER_FLAGS_EN
   logic [SHAMT_W-1:0] up_idx;
   logic [SHAMT_W-1:0] dn_idx;
   logic               carry_in;
   logic               a_carry;
   logic               b_carry;

   // Carry is the last bit to leave the operand, taken before shifting.
   always_comb begin
      carry_in = 1'b0;
      up_idx   = SHAMT_W'(0) - in_shamt;
      dn_idx   = in_shamt - SHAMT_W'(1);
      if (in_shamt != '0) begin
         case (in_mode)
            MODE_SLL, MODE_ROL:           carry_in = in_data[up_idx];
            MODE_SRL, MODE_SRA, MODE_ROR: carry_in = in_data[dn_idx];
            default:                      carry_in = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_carry <= 1'b0;
         b_carry <= 1'b0;
      end else begin
         if (in_fire) a_carry <= carry_in;
         if (b_load)  b_carry <= a_carry;
      end
   end

   assign out_carry = b_carry;
   assign out_zero  = b_valid && (b_data == '0);
`else
   assign out_carry = 1'b0;
   assign out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe (WIDTH=16) against a
// queue-based arithmetic reference model.
module tb_shifter_pipe;

`ifdef SHIFTER_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  tag;
      logic        carry;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_shamt;
   logic [2:0]  in_mode;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_tag;
   logic        out_carry;
   logic        out_zero;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t q[$];
   int acc_log[$];
   int out_log[$];
   bit ov_en = 1'b0;
   logic [15:0] ov_data;
   logic ov_carry;
   logic [15:0] held;

   shifter_pipe #(.WIDTH(16), .TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_carry (out_carry),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   // Reference: result and carry from plain 32-bit arithmetic.
   function automatic logic [16:0] ref_op(logic [15:0] d, int s, int m);
      logic [31:0] dd;
      logic [31:0] x;
      logic [31:0] se;
      logic [31:0] t;
      logic        c;
      dd = {d, d};
      x  = {16'h0, d};
      se = {{16{d[15]}}, d};
      case (m)
         0: t = x << s;
         1: t = se >> s;
         2: t = dd >> s;
         4: t = x >> s;
         5: t = (dd << s) >> 16;
         default: t = x;
      endcase
      c = 1'b0;
      if (s != 0) begin
         if (m == 0 || m == 5) c = d[16-s];
         else if (m == 1 || m == 2 || m == 4) c = d[s-1];
      end
      return {c, t[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit v, input logic [15:0] d,
                       input logic [3:0] sh, input logic [2:0] m,
                       input logic [3:0] t, input bit ordy);
      exp_t e;
      logic [16:0] r;
      in_valid  = v;
      in_data   = d;
      in_shamt  = sh;
      in_mode   = m;
      in_tag    = t;
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'(0));
         end else begin
            e = q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_tag", 32'(out_tag), 32'(e.tag));
            chk("out_carry", 32'(out_carry), 32'(FLAGS && e.carry));
            chk("out_zero", 32'(out_zero),
                32'(FLAGS && (e.data == 16'h0)));
            out_log.push_back(cyc);
         end
      end
      if (in_valid && in_ready) begin
         r = ref_op(d, int'(sh), int'(m));
         e.tag = t;
         e.data = ov_en ? ov_data : r[15:0];
         e.carry = ov_en ? ov_carry : r[16];
         q.push_back(e);
         acc_log.push_back(cyc);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
      chk({tag, "_out_data"}, 32'(out_data), 32'(0));
      chk({tag, "_out_tag"}, 32'(out_tag), 32'(0));
      chk({tag, "_out_carry"}, 32'(out_carry), 32'(0));
      chk({tag, "_out_zero"}, 32'(out_zero), 32'(0));
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b1);
   endtask

   initial begin
      int c0;
      int n0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_shamt = '0;
      in_mode = '0;
      in_tag = '0;
      out_ready = 1'b0;
      @(negedge clk);
      step(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b0);
      step(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b0);
      rst_n = 1'b1;
      chk_reset_state("reset");

      // Directed vectors with hand-computed results.
      ov_en = 1'b1;
      ov_data = 16'h8000; ov_carry = 1'b0;
      step(1'b1, 16'h0001, 4'd15, 3'b000, 4'd1, 1'b1);
      ov_data = 16'h0000; ov_carry = 1'b1;
      step(1'b1, 16'h8000, 4'd1, 3'b000, 4'd2, 1'b1);
      ov_data = 16'hF800; ov_carry = 1'b0;
      step(1'b1, 16'h8000, 4'd4, 3'b001, 4'd3, 1'b1);
      ov_data = 16'h0001; ov_carry = 1'b1;
      step(1'b1, 16'h0003, 4'd1, 3'b100, 4'd4, 1'b1);
      ov_data = 16'h8000; ov_carry = 1'b1;
      step(1'b1, 16'h0001, 4'd1, 3'b010, 4'd5, 1'b1);
      ov_data = 16'h0018; ov_carry = 1'b0;
      step(1'b1, 16'h8001, 4'd4, 3'b101, 4'd6, 1'b1);
      ov_data = 16'h1234; ov_carry = 1'b0;
      step(1'b1, 16'h1234, 4'd5, 3'b110, 4'd7, 1'b1);
      ov_en = 1'b0;
      drain(4);
      chk("directed_drained", 32'(q.size()), 32'(0));

      // Back-to-back throughput and latency.
      acc_log.delete();
      out_log.delete();
      for (int i = 0; i < 8; i++)
         step(1'b1, 16'($urandom), 4'($urandom), 3'($urandom), 4'(i), 1'b1);
      drain(4);
      c0 = acc_log.size() > 0 ? acc_log[0] : -100;
      chk("b2b_accepts", 32'(acc_log.size()), 32'(8));
      chk("b2b_outputs", 32'(out_log.size()), 32'(8));
      if (out_log.size() == 8) begin
         chk("b2b_latency", 32'(out_log[0]), 32'(c0 + 2));
         chk("b2b_span", 32'(out_log[7] - out_log[0]), 32'(7));
      end

      // Backpressure: two accepted, third stalls while output holds.
      acc_log.delete();
      step(1'b1, 16'h00F0, 4'd2, 3'b000, 4'd8, 1'b0);
      step(1'b1, 16'h0F00, 4'd3, 3'b100, 4'd9, 1'b0);
      chk("bp_accepts", 32'(acc_log.size()), 32'(2));
      held = q[0].data;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'hA5A5, 4'd7, 3'b101, 4'd10, 1'b0);
         chk("bp_in_ready", 32'(in_ready), 32'(0));
         chk("bp_out_valid", 32'(out_valid), 32'(1));
         chk("bp_hold", 32'(out_data), 32'(held));
      end
      chk("bp_no_accept", 32'(acc_log.size()), 32'(2));
      step(1'b1, 16'hA5A5, 4'd7, 3'b101, 4'd10, 1'b1);
      chk("bp_third_accept", 32'(acc_log.size()), 32'(3));
      n0 = out_log.size();
      drain(4);
      chk("bp_all_out", 32'(out_log.size() - n0), 32'(2));
      chk("bp_drained", 32'(q.size()), 32'(0));

      // Reset with both stages full discards everything.
      step(1'b1, 16'h1111, 4'd1, 3'b000, 4'd11, 1'b0);
      step(1'b1, 16'h2222, 4'd2, 3'b000, 4'd12, 1'b0);
      chk("rst_full", 32'(in_ready), 32'(0));
      rst_n = 1'b0;
      step(1'b0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b0);
      rst_n = 1'b1;
      q.delete();
      chk_reset_state("midrst");
      n0 = out_log.size();
      drain(4);
      chk("midrst_no_stale", 32'(out_log.size()), 32'(n0));

      // Random traffic with random backpressure.
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom),
              3'($urandom), 4'($urandom), $urandom_range(0, 2) != 0);
      for (int i = 0; i < 20 && q.size() != 0; i++) drain(1);
      chk("rand_drained", 32'(q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
